spo2_ratio_calc: RTL

// Downstream of the LED/PGA/DC-comp calibration controller. Consumes the per-channel
// ADC samples it latches (RED_ADC_Value, IR_ADC_Value) during OPERATION. Each

---
 rtl/spo2_ratio_calc_pkg.sv | 26 ++
 rtl/spo2_ratio_calc_seq_divider.sv | 90 +++++++++
 rtl/spo2_ratio_calc.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spo2_ratio_calc_pkg.sv
// Shared definitions for the SpO2 ratio path: FSM encoding, Q8.8 constants,
// default sizing and the DC midpoint helper.
package spo2_ratio_calc_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_CALC   = 2'd1,
      ST_DIVIDE = 2'd2
   } state_e;

   localparam int          Q_INT_BITS  = 8;
   localparam int          Q_FRAC_BITS = 8;
   localparam int          Q_W         = Q_INT_BITS + Q_FRAC_BITS;
   localparam logic [15:0] SAT_VAL     = 16'hFFFF;
   localparam int          WIN_LEN_DEF = 100;
   localparam int          DIV_W_DEF   = 24;
   localparam int          CNT_W       = 10;

   // DC level: midpoint of max and min, summed at 9 bits so nothing wraps
   function automatic logic [7:0] dc_of(input logic [7:0] mx, input logic [7:0] mn);
      logic [8:0] s;
      s = {1'b0, mx} + {1'b0, mn};
      return s[8:1];
   endfunction

endpackage

// File: rtl/spo2_ratio_calc_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The quotient is
// built in place in the dividend shift register. abort drops any divide.
module seq_divider
   import spo2_ratio_calc_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             abort,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [15:0]      divisor,
   output logic             busy,
   output logic             done,
   output logic [DIV_W-1:0] quotient,
   output logic             den0
);

   localparam int CW = $clog2(DIV_W + 1);

   logic [DIV_W-1:0] quo_q, quo_d;
   logic [15:0]      rem_q, rem_d;
   logic [15:0]      dsr_q, dsr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [16:0]      rem_sh;
   logic [16:0]      diff;

   // One restoring step per busy cycle; done pulses after the last bit
   always_comb begin
      quo_d  = quo_q;
      rem_d  = rem_q;
      dsr_d  = dsr_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      rem_sh = {rem_q, quo_q[DIV_W-1]};
      diff   = rem_sh - {1'b0, dsr_q};
      if (abort) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (start) begin
         quo_d  = dividend;
         rem_d  = '0;
         dsr_d  = divisor;
         cnt_d  = CW'(DIV_W);
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (rem_sh >= {1'b0, dsr_q}) begin
            rem_d = diff[15:0];
            quo_d = {quo_q[DIV_W-2:0], 1'b1};
         end else begin
            rem_d = rem_sh[15:0];
            quo_d = {quo_q[DIV_W-2:0], 1'b0};
         end
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // Divider state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dsr_q  <= dsr_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = quo_q;
   assign den0     = (divisor == 16'd0);

endmodule

// File: rtl/spo2_ratio_calc.sv
// SpO2 ratio: per-window AC/DC extraction on RED and IR, then
// R = (AC_red*DC_ir)/(AC_ir*DC_red) in unsigned Q8.8 via a sequential divide.
// Channel index 0 is RED, 1 is IR.
module spo2_ratio_calc
   import spo2_ratio_calc_pkg::*;
#(
   parameter int WIN_LEN = WIN_LEN_DEF,
   parameter int DIV_W   = DIV_W_DEF
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        enable,
   input  logic        red_valid,
   input  logic [7:0]  red_sample,
   input  logic        ir_valid,
   input  logic [7:0]  ir_sample,
   output logic [15:0] ratio,
   output logic        ratio_valid,
   output logic [7:0]  ac_red,
   output logic [7:0]  ac_ir,
   output logic [7:0]  dc_red,
   output logic [7:0]  dc_ir,
   output logic        div_err,
   output logic        sat,
   output logic        overrun
);

   localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN_LEN);

   logic [1:0]             vld;
   logic [1:0][7:0]        smp;
   logic [1:0]             acc;
   logic [1:0][CNT_W-1:0]  cnt_q, cnt_d, cnt_n;
   logic [1:0][7:0]        min_q, min_d, mn_n;
   logic [1:0][7:0]        max_q, max_d, mx_n;
   logic                   close;

   state_e                 state_q, state_d;
   logic [1:0][7:0]        ac_q, ac_d, dc_q, dc_d;
   logic [15:0]            ratio_q, ratio_d;
   logic                   rv_q, rv_d;
   logic                   div_err_q, div_err_d;
   logic                   sat_q, sat_d;
   logic                   ovr_q, ovr_d;

   logic [15:0]            p_num, den;
   logic [DIV_W-1:0]       num, quo;
   logic                   div_start, div_busy, div_done, div_den0;

   assign vld = {ir_valid, red_valid};
   assign smp = {ir_sample, red_sample};

   // Min/max/count tracking per channel; runs in every FSM state
   always_comb begin
      acc   = '0;
      cnt_n = cnt_q;
      mn_n  = min_q;
      mx_n  = max_q;
      for (int c = 0; c < 2; c++) begin
         acc[c]   = enable && vld[c] && (cnt_q[c] != WIN_CNT);
         cnt_n[c] = cnt_q[c] + CNT_W'(acc[c]);
         mn_n[c]  = (acc[c] && smp[c] < min_q[c]) ? smp[c] : min_q[c];
         mx_n[c]  = (acc[c] && smp[c] > max_q[c]) ? smp[c] : max_q[c];
      end
      close = enable && (cnt_n[0] == WIN_CNT) && (cnt_n[1] == WIN_CNT);
      cnt_d = cnt_n;
      min_d = mn_n;
      max_d = mx_n;
      if (!enable || close) begin
         cnt_d = '0;
         min_d = {2{8'hFF}};
         max_d = '0;
      end
   end

   // Ratio operands from the latched AC/DC of the closed window
   always_comb begin
      p_num = {8'h00, ac_q[0]} * {8'h00, dc_q[1]};
      den   = {8'h00, ac_q[1]} * {8'h00, dc_q[0]};
      num   = DIV_W'({p_num, 8'h00});
   end

   // Window FSM: ACCUM -> CALC -> DIVIDE -> ACCUM, with registered outputs
   always_comb begin
      state_d   = state_q;
      ac_d      = ac_q;
      dc_d      = dc_q;
      ratio_d   = ratio_q;
      rv_d      = 1'b0;
      div_err_d = div_err_q;
      sat_d     = sat_q;
      ovr_d     = 1'b0;
      div_start = 1'b0;
      if (!enable) begin
         state_d = ST_ACCUM;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (close) begin
                  for (int c = 0; c < 2; c++) begin
                     ac_d[c] = mx_n[c] - mn_n[c];
                     dc_d[c] = dc_of(mx_n[c], mn_n[c]);
                  end
                  state_d = ST_CALC;
               end
            end
            ST_CALC: begin
               ovr_d = close;
               if (div_den0) begin
                  ratio_d   = SAT_VAL;
                  rv_d      = 1'b1;
                  div_err_d = 1'b1;
                  sat_d     = 1'b0;
                  state_d   = ST_ACCUM;
               end else begin
                  div_start = 1'b1;
                  state_d   = ST_DIVIDE;
               end
            end
            ST_DIVIDE: begin
               ovr_d = close;
               if (div_done) begin
                  rv_d      = 1'b1;
                  div_err_d = 1'b0;
                  sat_d     = ((quo >> Q_W) != '0);
                  ratio_d   = sat_d ? SAT_VAL : quo[15:0];
                  state_d   = ST_ACCUM;
               end else if (!div_busy) begin
                  state_d = ST_ACCUM;
               end
            end
            default: state_d = ST_ACCUM;
         endcase
      end
   end

   // All top-level state in one register block
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q   <= ST_ACCUM;
         cnt_q     <= '0;
         min_q     <= {2{8'hFF}};
         max_q     <= '0;
         ac_q      <= '0;
         dc_q      <= '0;
         ratio_q   <= '0;
         rv_q      <= 1'b0;
         div_err_q <= 1'b0;
         sat_q     <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         min_q     <= min_d;
         max_q     <= max_d;
         ac_q      <= ac_d;
         dc_q      <= dc_d;
         ratio_q   <= ratio_d;
         rv_q      <= rv_d;
         div_err_q <= div_err_d;
         sat_q     <= sat_d;
         ovr_q     <= ovr_d;
      end
   end

   seq_divider #(.DIV_W(DIV_W)) u_div (
      .clk      (CLK),
      .rst      (rst),
      .abort    (!enable),
      .start    (div_start),
      .dividend (num),
      .divisor  (den),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (quo),
      .den0     (div_den0)
   );

   assign ratio       = ratio_q;
   assign ratio_valid = rv_q;
   assign ac_red      = ac_q[0];
   assign ac_ir       = ac_q[1];
   assign dc_red      = dc_q[0];
   assign dc_ir       = dc_q[1];
   assign div_err     = div_err_q;
   assign sat         = sat_q;
   assign overrun     = ovr_q;

endmodule
